// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy
// states and the control-bundle bit layout each stage instance agrees on.
package pipe_pkg;

    // Occupancy states; the encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // ID/EX control bundle layout
    localparam int EX_REGDST    = 0;
    localparam int EX_ALUSRC    = 1;
    localparam int EX_ALUOP_LO  = 2;
    localparam int EX_ALUOP_HI  = 3;
    localparam int EX_MEMREAD   = 4;
    localparam int EX_MEMWRITE  = 5;

    // EX/MEM control bundle layout
    localparam int M_MEMREAD    = 3;
    localparam int M_MEMWRITE   = 4;
    localparam int M_BRANCH     = 5;

    // MEM/WB control bundle layout (also the low bits of EX/MEM)
    localparam int WB_REGWRITE  = 0;
    localparam int WB_MEMTOREG  = 1;
    localparam int WB_HILOTOREG = 2;

    // Number of held entries for a given occupancy state.
    function automatic logic [1:0] state_count(input pipe_state_t s);
        return logic'(s == FULL) ? 2'd2 : ((s == ONE) ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline register: a data bundle and a control
// bundle. Clearing only zeroes the control bundle so the entry becomes a
// bubble while its data stays visible.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_in,
    input  logic [CTRL_W-1:0] c_in,
    output logic [DATA_W-1:0] d_out,
    output logic [CTRL_W-1:0] c_out
);

    // Entry storage: clear beats load, reset zeroes both bundles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out <= '0;
            c_out <= '0;
        end else if (clear) begin
            c_out <= '0;
        end else if (load) begin
            d_out <= d_in;
            c_out <= c_in;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush and occupancy count.
//
// Handshake: an entry is accepted when InValid & InReady are both high at a
// capture edge and popped when OutValid & OutReady are both high at a capture
// edge. InValid/InData/InCtrl must be held until accepted; OutValid never
// drops without a pop, a flush or reset.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 6,
    parameter int SKID    = 1,
    parameter int NEGEDGE = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [1:0]        Count
);

    logic              cap_clk;
    pipe_state_t       state;
    pipe_state_t       next_state;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              accept;
    logic              pop;
    logic              head_load;
    logic              head_from_skid;
    logic              head_clear;
    logic              skid_load;
    logic [DATA_W-1:0] head_d_in;
    logic [CTRL_W-1:0] head_c_in;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Every register in the block runs off this one capture clock.
    generate
        if (NEGEDGE != 0) begin : g_negedge
            assign cap_clk = ~Clk;
        end else begin : g_posedge
            assign cap_clk = Clk;
        end
    endgenerate

    // Skid mode has a registered ready; single-entry mode lets a pop free the
    // slot in the same cycle.
    assign InReady  = (SKID != 0) ? in_ready_q : (!out_valid_q || OutReady);
    assign OutValid = out_valid_q;
    assign Count    = state_count(state);

    assign accept = InValid && InReady;
    assign pop    = out_valid_q && OutReady;

    // Next-state and slot enable decode; flush overrides every other event.
    always_comb begin
        next_state     = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_clear     = 1'b0;
        skid_load      = 1'b0;
        if (Flush) begin
            next_state = EMPTY;
            head_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_load  = 1'b1;
                        next_state = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        // Only reachable with a skid entry present.
                        if (SKID != 0) begin
                            skid_load  = 1'b1;
                            next_state = FULL;
                        end
                    end else if (pop) begin
                        head_clear = 1'b1;
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: begin
                    next_state = EMPTY;
                    head_clear = 1'b1;
                end
            endcase
        end
    end

    // Occupancy FSM with registered OutValid and skid-mode InReady.
    always_ff @(posedge cap_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= next_state;
            out_valid_q <= (next_state != EMPTY);
            in_ready_q  <= (next_state != FULL);
        end
    end

    // Head refills from the skid entry when draining FULL, else from input.
    assign head_d_in = head_from_skid ? skid_data : InData;
    assign head_c_in = head_from_skid ? skid_ctrl : InCtrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clk   (cap_clk),
        .rst_n (Rst_n),
        .load  (head_load),
        .clear (head_clear),
        .d_in  (head_d_in),
        .c_in  (head_c_in),
        .d_out (OutData),
        .c_out (OutCtrl)
    );

    // Second entry exists only in skid mode.
    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk   (cap_clk),
                .rst_n (Rst_n),
                .load  (skid_load),
                .clear (1'b0),
                .d_in  (InData),
                .c_in  (InCtrl),
                .d_out (skid_data),
                .c_out (skid_ctrl)
            );
        end else begin : g_no_skid
            logic unused_skid_load;
            assign unused_skid_load = skid_load;
            assign skid_data        = '0;
            assign skid_ctrl        = '0;
        end
    endgenerate

endmodule
